udp_panel_reader: RTL

Read-back/transmit counterpart of the UDP panel write path. Accepts a read request naming a panel, start address and entry count. Reads the panel control memory one entry at a time and emits one UDP packet toward the UDP core's sink stream, one byte per beat. Each entry is 4 bytes, the same format the write path consumes: addr[15:8], addr[7:0], data[15:8], data[7:0]. Sits beside the write path between the panel controllers and the Ethernet UDP core.

---
 rtl/udp_panel_reader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/udp_panel_reader.sv
// Panel read-back engine: reads panel control memory entry by entry and
// streams the entries as a single UDP packet, one byte per beat.
module udp_panel_reader #(
  parameter logic [7:0] PORT_MSB   = 8'h66,
  parameter int         RD_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_panel,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_count,
  input  logic [31:0] req_ip,
  input  logic [15:0] req_port,
  output logic [5:0]  rd_en,
  output logic [15:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic        udp_sink_valid,
  output logic        udp_sink_last,
  input  logic        udp_sink_ready,
  output logic [15:0] udp_sink_src_port,
  output logic [15:0] udp_sink_dst_port,
  output logic [31:0] udp_sink_ip_address,
  output logic [15:0] udp_sink_length,
  output logic [31:0] udp_sink_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    SEND
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

  state_t      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic [5:0]  panel_q, panel_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] ip_q, ip_d;
  logic [15:0] dport_q, dport_d;
  logic [15:0] sport_q, sport_d;
  logic [15:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  beat_q, beat_d;
  logic [2:0]  lat_q, lat_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      panel_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ip_q    <= '0;
      dport_q <= '0;
      sport_q <= '0;
      len_q   <= '0;
      word_q  <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      panel_q <= panel_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ip_q    <= ip_d;
      dport_q <= dport_d;
      sport_q <= sport_d;
      len_q   <= len_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    panel_d = panel_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ip_d    = ip_q;
    dport_d = dport_q;
    sport_d = sport_q;
    len_d   = len_q;
    word_d  = word_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && rdy_q) begin
          panel_d = req_panel;
          addr_d  = req_addr;
          cnt_d   = req_count;
          ip_d    = req_ip;
          dport_d = req_port;
          sport_d = {PORT_MSB, 2'b00, req_panel};
          len_d   = {6'b0, req_count, 2'b00};
          if (req_count != 8'd0) begin
            state_d = READ;
          end
        end
      end
      READ: begin
        lat_d   = 3'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          word_d  = {addr_q, rd_data};
          beat_d  = 2'd0;
          state_d = SEND;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      SEND: begin
        if (udp_sink_ready) begin
          if (beat_q == 2'd3) begin
            if (cnt_q == 8'd1) begin
              cnt_d   = 8'd0;
              state_d = IDLE;
            end else begin
              addr_d  = addr_q + 16'd1;
              cnt_d   = cnt_q - 8'd1;
              state_d = READ;
            end
          end else begin
            beat_d = beat_q + 2'd1;
            word_d = {word_q[23:0], 8'h00};
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // ready is registered so it stays low while reset is asserted
    rdy_d = (state_d == IDLE);
  end

  assign req_ready           = rdy_q;
  assign busy                = (state_q != IDLE);
  assign rd_en               = (state_q == READ) ? panel_q : 6'd0;
  assign rd_addr             = addr_q;
  assign udp_sink_valid      = (state_q == SEND);
  assign udp_sink_last       = (state_q == SEND) && (beat_q == 2'd3)
                               && (cnt_q == 8'd1);
  assign udp_sink_data       = {24'd0, word_q[31:24]};
  assign udp_sink_src_port   = sport_q;
  assign udp_sink_dst_port   = dport_q;
  assign udp_sink_ip_address = ip_q;
  assign udp_sink_length     = len_q;

endmodule
